// File: rtl/pipe_data_reg.sv
// Multi-stage data register chain with per-stage valid bits, stall, flush,
// occupancy count, selectable capture edge and optional bubble collapse.
module pipe_data_reg #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter bit               NEG_EDGE  = 1'b1,
  parameter bit               COLLAPSE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WIDTH-1:0]           DataIn,
  input  logic                       ValidIn,
  output logic                       InReady,
  input  logic                       Stall,
  input  logic                       Flush,
  output logic [WIDTH-1:0]           DataOut,
  output logic                       ValidOut,
  output logic [$clog2(DEPTH+1)-1:0] Count
);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_nxt;
  logic [DEPTH-1:0]            v_q, v_nxt, adv;
  logic [CW-1:0]               cnt_q, cnt_nxt;

  // A stage moves when the output drains, or in collapse mode when some
  // stage at or above it holds a bubble that can absorb the shift.
  always_comb begin
    logic hole;
    hole = 1'b0;
    adv  = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      hole   = hole | ~v_q[k];
      adv[k] = ~Stall | (COLLAPSE & hole);
    end
  end

  always_comb begin
    d_nxt   = d_q;
    v_nxt   = v_q;
    cnt_nxt = cnt_q;
    if (Flush) begin
      d_nxt   = {DEPTH{RESET_VAL}};
      v_nxt   = '0;
      cnt_nxt = '0;
    end else begin
      if (adv[0]) begin
        d_nxt[0] = DataIn;
        v_nxt[0] = ValidIn;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k]) begin
          d_nxt[k] = d_q[k-1];
          v_nxt[k] = v_q[k-1];
        end
      end
      cnt_nxt = cnt_q + CW'(ValidIn & adv[0]) - CW'(v_q[DEPTH-1] & ~Stall);
    end
  end

  // Only one of these register banks is elaborated, chosen by the capture edge.
  generate
    if (NEG_EDGE) begin : g_neg
      always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
          d_q   <= {DEPTH{RESET_VAL}};
          v_q   <= '0;
          cnt_q <= '0;
        end else begin
          d_q   <= d_nxt;
          v_q   <= v_nxt;
          cnt_q <= cnt_nxt;
        end
      end
    end else begin : g_pos
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          d_q   <= {DEPTH{RESET_VAL}};
          v_q   <= '0;
          cnt_q <= '0;
        end else begin
          d_q   <= d_nxt;
          v_q   <= v_nxt;
          cnt_q <= cnt_nxt;
        end
      end
    end
  endgenerate

  assign InReady  = adv[0];
  assign DataOut  = d_q[DEPTH-1];
  assign ValidOut = v_q[DEPTH-1];
  assign Count    = cnt_q;

endmodule

// File: tb/tb_pipe_data_reg.sv
// Self-checking bench: four differently configured chains share one stimulus
// stream and are compared every cycle against a slot-array model.
`timescale 1ns/1ps
module tb_pipe_data_reg;
  localparam int          N        = 4;
  localparam int          DEP [N]  = '{2, 3, 3, 1};
  localparam bit          COL [N]  = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam bit          NEG [N]  = '{1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [31:0] RV  [N]  = '{32'hDEAD_BEEF, 32'h0000_0000, 32'h5A5A_0000, 32'hFFFF_FFFF};

  logic        CLK     = 1'b0;
  logic        RST     = 1'b0;
  logic [31:0] DataIn  = '0;
  logic        ValidIn = 1'b0;
  logic        Stall   = 1'b0;
  logic        Flush   = 1'b0;

  logic [31:0] dout [N];
  logic        vout [N];
  logic        rdy  [N];
  logic [1:0]  cnt0, cnt1, cnt2;
  logic [0:0]  cnt3;
  int          cntv [N];

  int checks = 0;
  int errors = 0;

  assign cntv[0] = int'(cnt0);
  assign cntv[1] = int'(cnt1);
  assign cntv[2] = int'(cnt2);
  assign cntv[3] = int'(cnt3);

  always #5 CLK = ~CLK;

  pipe_data_reg #(.WIDTH(32), .DEPTH(2), .NEG_EDGE(1'b1), .COLLAPSE(1'b0), .RESET_VAL(32'hDEAD_BEEF)) u0 (
    .CLK(CLK), .RST(RST), .DataIn(DataIn), .ValidIn(ValidIn), .InReady(rdy[0]), .Stall(Stall),
    .Flush(Flush), .DataOut(dout[0]), .ValidOut(vout[0]), .Count(cnt0));
  pipe_data_reg #(.WIDTH(32), .DEPTH(3), .NEG_EDGE(1'b1), .COLLAPSE(1'b1), .RESET_VAL(32'h0000_0000)) u1 (
    .CLK(CLK), .RST(RST), .DataIn(DataIn), .ValidIn(ValidIn), .InReady(rdy[1]), .Stall(Stall),
    .Flush(Flush), .DataOut(dout[1]), .ValidOut(vout[1]), .Count(cnt1));
  pipe_data_reg #(.WIDTH(32), .DEPTH(3), .NEG_EDGE(1'b0), .COLLAPSE(1'b0), .RESET_VAL(32'h5A5A_0000)) u2 (
    .CLK(CLK), .RST(RST), .DataIn(DataIn), .ValidIn(ValidIn), .InReady(rdy[2]), .Stall(Stall),
    .Flush(Flush), .DataOut(dout[2]), .ValidOut(vout[2]), .Count(cnt2));
  pipe_data_reg #(.WIDTH(32), .DEPTH(1), .NEG_EDGE(1'b0), .COLLAPSE(1'b1), .RESET_VAL(32'hFFFF_FFFF)) u3 (
    .CLK(CLK), .RST(RST), .DataIn(DataIn), .ValidIn(ValidIn), .InReady(rdy[3]), .Stall(Stall),
    .Flush(Flush), .DataOut(dout[3]), .ValidOut(vout[3]), .Count(cnt3));

  // Model: slot arrays per instance, current (m*) and after-edge (n*) views.
  bit          mv [N][8];
  logic [31:0] md [N][8];
  bit          nv [N][8];
  logic [31:0] nd [N][8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, want);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] d,
                               input logic s, input logic f);
    @(negedge CLK);
    #1;
    RST = r; ValidIn = v; DataIn = d; Stall = s; Flush = f;
    #2;
  endtask

  function automatic void modelReset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) begin
        mv[i][k] = 1'b0;
        md[i][k] = RV[i];
      end
  endfunction

  function automatic int modelCount(int i);
    int c = 0;
    for (int k = 0; k < DEP[i]; k++) c += int'(mv[i][k]);
    return c;
  endfunction

  function automatic bit modelReady(int i);
    bit hole = 1'b0;
    for (int k = 0; k < DEP[i]; k++) if (!mv[i][k]) hole = 1'b1;
    return !Stall || (COL[i] && hole);
  endfunction

  // Without stall the whole chain shifts; with stall in collapse mode every
  // slot from the topmost bubble downwards shifts; otherwise nothing moves.
  function automatic void modelNext();
    for (int i = 0; i < N; i++) begin
      int top;
      for (int k = 0; k < 8; k++) begin
        nv[i][k] = mv[i][k];
        nd[i][k] = md[i][k];
      end
      top = -1;
      if (!RST || Flush) begin
        for (int k = 0; k < 8; k++) begin
          nv[i][k] = 1'b0;
          nd[i][k] = RV[i];
        end
      end else if (!Stall) begin
        top = DEP[i] - 1;
      end else if (COL[i]) begin
        for (int k = 0; k < DEP[i]; k++) if (!mv[i][k]) top = k;
      end
      for (int k = top; k >= 1; k--) begin
        nd[i][k] = md[i][k-1];
        nv[i][k] = mv[i][k-1];
      end
      if (top >= 0) begin
        nd[i][0] = DataIn;
        nv[i][0] = ValidIn;
      end
    end
  endfunction

  initial begin : compare
    forever begin
      @(negedge CLK);
      #3;
      if (!RST) modelReset();
      for (int i = 0; i < N; i++) begin
        checkOutput($sformatf("dout%0d", i), dout[i], md[i][DEP[i]-1]);
        checkOutput($sformatf("vout%0d", i), 32'(vout[i]), 32'(mv[i][DEP[i]-1]));
        checkOutput($sformatf("count%0d", i), 32'(cntv[i]), 32'(modelCount(i)));
        checkOutput($sformatf("inready%0d", i), 32'(rdy[i]), 32'(modelReady(i)));
      end
      modelNext();
      #4;
      for (int i = 0; i < N; i++) begin
        if (NEG[i]) begin
          checkOutput($sformatf("mid_dout%0d", i), dout[i], md[i][DEP[i]-1]);
          checkOutput($sformatf("mid_vout%0d", i), 32'(vout[i]), 32'(mv[i][DEP[i]-1]));
        end else begin
          checkOutput($sformatf("mid_dout%0d", i), dout[i], nd[i][DEP[i]-1]);
          checkOutput($sformatf("mid_vout%0d", i), 32'(vout[i]), 32'(nv[i][DEP[i]-1]));
        end
      end
      for (int i = 0; i < N; i++)
        for (int k = 0; k < 8; k++) begin
          md[i][k] = nd[i][k];
          mv[i][k] = nv[i][k];
        end
    end
  end

  initial begin : stimulus
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("reset_dout", dout[0], 32'hDEAD_BEEF);
    checkOutput("reset_vout", 32'(vout[0]), 32'd0);
    checkOutput("reset_count", 32'(cntv[0]), 32'd0);
    checkOutput("reset_inready", 32'(rdy[0]), 32'd1);
    checkOutput("reset_dout_d1", dout[3], 32'hFFFF_FFFF);

    // Rising-edge instance captures before the falling-edge one does.
    applyStimulus(1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
    #3;
    checkOutput("posedge_captured", 32'(cntv[2]), 32'd1);
    checkOutput("negedge_waiting", 32'(cntv[1]), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

    applyStimulus(1'b1, 1'b1, 32'h1, 1'b0, 1'b0);
    checkOutput("stream_count0", 32'(cntv[1]), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h2, 1'b0, 1'b0);
    checkOutput("stream_count1", 32'(cntv[1]), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
    checkOutput("stream_count2", 32'(cntv[1]), 32'd2);
    applyStimulus(1'b1, 1'b1, 32'h4, 1'b0, 1'b0);
    checkOutput("stream_first_dout", dout[1], 32'h1);
    checkOutput("stream_first_vout", 32'(vout[1]), 32'd1);
    checkOutput("stream_count3", 32'(cntv[1]), 32'd3);
    applyStimulus(1'b1, 1'b1, 32'h5, 1'b0, 1'b0);
    checkOutput("stream_second_dout", dout[1], 32'h2);
    checkOutput("stream_count_steady", 32'(cntv[1]), 32'd3);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("stream_third_dout", dout[1], 32'h3);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 32'hA, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hB, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b1, 1'b1, 32'hC, 1'b1, 1'b0);
      checkOutput("stall_dout", dout[0], 32'hA);
      checkOutput("stall_count", 32'(cntv[0]), 32'd2);
      checkOutput("stall_inready", 32'(rdy[0]), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("stall_release_dout", dout[0], 32'hA);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("stall_second_dout", dout[0], 32'hB);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("stall_no_c_vout", 32'(vout[0]), 32'd0);
    checkOutput("stall_no_c_count", 32'(cntv[0]), 32'd0);

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'hA1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hB1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hC1, 1'b1, 1'b0);
    checkOutput("collapse_bubble_ready", 32'(rdy[1]), 32'd1);
    checkOutput("collapse_pre_count", 32'(cntv[1]), 32'd2);
    applyStimulus(1'b1, 1'b1, 32'hE1, 1'b1, 1'b0);
    checkOutput("collapse_full_ready", 32'(rdy[1]), 32'd0);
    checkOutput("collapse_full_count", 32'(cntv[1]), 32'd3);
    checkOutput("collapse_dout", dout[1], 32'hA1);
    applyStimulus(1'b1, 1'b1, 32'hE1, 1'b1, 1'b0);
    checkOutput("collapse_hold_count", 32'(cntv[1]), 32'd3);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("collapse_out_a", dout[1], 32'hA1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("collapse_out_b", dout[1], 32'hB1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("collapse_out_c", dout[1], 32'hC1);

    applyStimulus(1'b1, 1'b1, 32'h101, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h102, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hD00D, 1'b0, 1'b1);
    checkOutput("flush_pre_count", 32'(cntv[0]), 32'd2);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("flush_vout", 32'(vout[0]), 32'd0);
    checkOutput("flush_count", 32'(cntv[0]), 32'd0);
    checkOutput("flush_dout", dout[0], 32'hDEAD_BEEF);
    for (int n = 0; n < 2; n++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("flush_no_d_vout", 32'(vout[0]), 32'd0);
      checkOutput("flush_no_d_data", 32'(dout[0] != 32'hD00D), 32'd1);
    end

    applyStimulus(1'b1, 1'b1, 32'h201, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h202, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("async_pre_count", 32'(cntv[0]), 32'd2);
    applyStimulus(1'b0, 1'b1, 32'h203, 1'b1, 1'b0);
    checkOutput("async_vout", 32'(vout[0]), 32'd0);
    checkOutput("async_count", 32'(cntv[0]), 32'd0);
    checkOutput("async_dout", dout[0], 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      logic r, f, s, v;
      r = ($urandom_range(0, 49) != 0);
      f = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 2) == 0);
      v = ($urandom_range(0, 3) != 0);
      applyStimulus(r, v, $urandom, s, f);
    end

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #10;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_data_reg.md
Name: pipe_data_reg

Overview:
- Parametrised multi-stage data register chain for the pipelined datapath.
- Generalises the single-stage falling-edge data register: configurable width, depth and capture edge.
- Adds per-stage valid tracking, stall, flush and an occupancy count.
- Optional bubble-collapse mode lets invalid stages be filled while the output is stalled. Used between datapath stages and as a short elastic delay line ahead of the register file and memory.

Parameters:
- WIDTH, 32, data bits per stage.
- DEPTH, 2, number of register stages (legal range 1..8).
- NEG_EDGE, 1: 1 = capture on falling CLK edge; 0 = rising edge.
- COLLAPSE, 0: 1 = invalid stages advance during Stall; 0 = Stall freezes every stage.
- RESET_VAL, 32'h0000_0000, data value loaded on reset and flush (WIDTH bits).

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous reset, active-low.
- DataIn  input  WIDTH  data entering stage 0.
- ValidIn  input  1  DataIn is a real item.
- InReady  output  1  stage 0 loads on this active edge (combinational).
- Stall  input  1  downstream cannot take DataOut; output stage holds.
- Flush  input  1  synchronous kill of all stages.
- DataOut  output  WIDTH  data in stage DEPTH-1.
- ValidOut  output  1  valid bit of stage DEPTH-1.
- Count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Active edge: negedge CLK if NEG_EDGE=1, else posedge. RST is asynchronous on either setting.
- Reset (RST=0), taking effect immediately regardless of clock: all stage data = RESET_VAL, all valid bits = 0, Count = 0. So DataOut = RESET_VAL, ValidOut = 0.
- State per stage k: d[k], v[k]. Stage 0 is the input; stage DEPTH-1 drives DataOut/ValidOut.
- Advance terms, combinational:
  - adv[DEPTH] = !Stall.
  - COLLAPSE=0: adv[k] = !Stall for every k.
  - COLLAPSE=1: adv[k] = adv[k+1] | !v[k], evaluated from k = DEPTH-1 down to 0.
- InReady = adv[0].
- Priority at each active edge: Flush > normal update.
  - Flush=1: all v = 0, all d = RESET_VAL, Count = 0. A ValidIn presented in that cycle is dropped, even if InReady=1.
  - Normal update:
    - For k>0 with adv[k]=1: d[k] <= d[k-1], v[k] <= v[k-1].
    - Stage 0 with adv[0]=1: d[0] <= DataIn, v[0] <= ValidIn.
    - Any stage with adv[k]=0 holds.
    - A stage that loads from an invalid predecessor becomes invalid; its data is don't-care but must be the predecessor's d, with no extra muxing.
- Count, registered:
  - next = Count + (ValidIn & InReady) - (ValidOut & !Stall).
  - Simultaneous accept and retire leaves Count unchanged.
  - Count never exceeds DEPTH and never underflows.
  - Invariant: Count == popcount(v).
- Latency:
  - No stalls: ValidIn at edge n appears on ValidOut after edge n+DEPTH-1 (stage 0 loaded at edge n). DEPTH=1 gives single-edge latency, identical to a plain data register.
  - Throughput: one item per edge.
- Stall behaviour:
  - COLLAPSE=0: everything holds, InReady=0, inputs are ignored.
  - COLLAPSE=1, all stages valid: InReady=0, nothing moves.
  - COLLAPSE=1, any invalid stage: stages upstream of the lowest-index bubble... more precisely, every stage at or above... every stage k for which some j ≥ k has v[j]=0 advances. The bubble is squeezed out one position per edge.
- Reset mid-stall or mid-flush: reset wins instantly. After release, the first active edge behaves as a normal update from the empty state.
- Outputs are glitch-free registered values, except InReady, which is combinational from Stall and v.

Test Plan:
- Reset/idle: RST=0 then release, DEPTH=2, RESET_VAL=32'hDEAD_BEEF -> DataOut=32'hDEAD_BEEF, ValidOut=0, Count=0, InReady=1.
- Streaming, DEPTH=3, NEG_EDGE=1: present 32'h1, 32'h2, 32'h3 valid on consecutive falling edges -> 32'h1 on DataOut with ValidOut=1 after the 3rd falling edge. Then 2 and 3 follow on successive edges. Count rises 1, 2, 3, then stays 3 while streaming continues.
- Stall, COLLAPSE=0, DEPTH=2, pipe full (A in out stage, B behind): Stall=1 for 3 edges with ValidIn=1 C -> DataOut=A held, InReady=0, C never captured, Count=2.
- Bubble collapse, COLLAPSE=1, DEPTH=3, stages {out:A, mid:invalid, in:B}: Stall=1, ValidIn=1 C -> after 1 edge stages {A, B, C}, Count=3. Next edge InReady=0 and nothing moves.
- Flush priority: full DEPTH=2 pipe, Flush=1 together with ValidIn=1 D and Stall=0 -> next edge ValidOut=0, Count=0, DataOut=RESET_VAL, D absent on every later edge.
- Async reset mid-operation: assert RST=0 between clock edges while Count=2 -> ValidOut=0 and Count=0 immediately, without waiting for a clock edge. With NEG_EDGE=0, a capture happens on the rising edge only.
